snes_pad_responder: RTL and testbench
=====================================

Name: snes_pad_responder

Overview:
- Controller-side end of the SNES serial joypad interface: responds to the console's JOY_STRB / JOY_CLK / JOY_P6 outputs and returns serial button data on the JOY_DI lines.
- One instance per controller port, sitting beside the SNES core in the MCLK domain.
- Models a standard pad, or a 4-pad multitap when MULTITAP=1, from parallel button vectors supplied by the frontend.

Parameters:
- NBITS, 16, serial frame length before the fill value starts.
- MT_ID_LOW, 1, when 1 a multitap drives JOY_DI[1]=0 while JOY_STRB is high (tap signature).

Ports:
- MCLK  in  1  system master clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- MULTITAP  in  1  0 = single pad on DI[0]; 1 = 4-pad multitap. Only sampled while JOY_STRB is high.
- JOY_STRB  in  1  latch strobe from the console, level-sensitive.
- JOY_CLK  in  1  shift clock from the console, idles high; a shift happens on the rising edge.
- JOY_P6  in  1  multitap pair select: 1 = pads 0/1, 0 = pads 2/3.
- BTN0  in  12  pad 0 buttons, active-high: {R,L,X,A,Right,Left,Down,Up,Start,Select,Y,B}, B is bit 0.
- BTN1  in  12  pad 1 buttons, same order.
- BTN2  in  12  pad 2 buttons, same order.
- BTN3  in  12  pad 3 buttons, same order.
- JOY_DI  out  2  serial data to the console, active-low on the wire (0 = pressed).
- LATCH_PULSE  out  1  one-MCLK pulse on each falling edge of JOY_STRB.

Behaviour:
- Input registering:
  - JOY_STRB, JOY_CLK and JOY_P6 are registered once (s1) and then once more (s2).
  - Edges are detected from s1 vs s2.
  - All actions below take effect one MCLK after the edge appears at the pins, plus one more for the JOY_DI register.
- Frame per pad:
  - 16-bit shift register SR = {4'b0000, BTNn}; bit 0 is presented first.
  - Bits 12..15 are the ID bits (0 = standard pad).
  - JOY_DI bit = ~SR[0] while the count is below NBITS.
  - Once the count reaches NBITS, JOY_DI = 0 (console reads 1s), for as long as it stays saturated.
- Latch:
  - While s2 STRB=1, every cycle reloads all four SRs from BTN0..3, clears all four 5-bit counters and re-samples MULTITAP into mt_mode.
  - Clock edges are ignored while STRB is high.
  - STRB falling edge: LATCH_PULSE=1 for one cycle; the registers hold their reload values.
- Shift: on an s1/s2 JOY_CLK rising edge with STRB low:
  - SR >>= 1, filling with 1.
  - The counter increments and saturates at NBITS.
  - Only the pads currently addressed shift:
    - mt_mode=0: pad 0 only.
    - mt_mode=1, P6=1: pads 0 and 1.
    - mt_mode=1, P6=0: pads 2 and 3.
- Output mux, registered:
  - mt_mode=0: DI[0] = pad 0, DI[1] = 1.
  - mt_mode=1, P6=1: DI[0] = pad 0, DI[1] = pad 1.
  - mt_mode=1, P6=0: DI[0] = pad 2, DI[1] = pad 3.
  - Override: mt_mode=1, MT_ID_LOW=1 and STRB high forces DI[1] = 0.
- Simultaneous events:
  - STRB high and a clock edge in the same cycle: latch wins, no shift.
  - P6 change and a clock edge in the same cycle: the shift uses the P6 value registered in s2.
- P6 toggling mid-frame: each pair keeps its own position; switching pairs does not reset counters.
- MULTITAP changing while STRB is low: no effect until the next strobe.
- Button inputs: sampled only during latch. Changes while STRB is low do not alter an in-flight frame.
- Reset (asynchronous, any time including mid-frame):
  - All SRs = 16'hFFFF, counters = NBITS (saturated), mt_mode = 0.
  - Sync registers: STRB=0, CLK=1, P6=1.
  - JOY_DI = 2'b11, LATCH_PULSE = 0.
  - After reset is released, the block outputs fill until the next strobe.
- Counters are 5 bits; increment arithmetic never wraps because it saturates at NBITS.

Test Plan:
1. Single pad basic frame.
   - Stimulus: MULTITAP=0, BTN0=12'h001 (B), STRB pulse, then 16 CLK low/high pulses.
   - Required: DI[0] = 0 before the first clock (B pressed), 1 for bits 1..15, 0 after clock 16; DI[1] = 1 throughout; LATCH_PULSE fires exactly once.
2. Saturation and fill.
   - Stimulus: 20 clocks after a strobe with BTN0=12'hFFF.
   - Required: bits 0..11 = 0, bits 12..15 = 1, bits 16..19 = 0, counter stays at 16.
3. Multitap pair select.
   - Stimulus: MULTITAP=1, BTN0=12'h800 (R), BTN1=0, BTN2=12'h010 (Up), BTN3=0; with P6=1 clock 12 bits, then P6=0 clock 5 bits.
   - Required, P6=1 phase: DI[0] is low only on bit 11; DI[1] stays high.
   - Required, P6=0 phase: DI[0] is low on bit 4, which is pad 2's fresh frame.
4. Strobe priority.
   - Stimulus: assert a CLK rising edge in the same MCLK as STRB high.
   - Required: counter stays 0; after STRB falls, the first bit is still B.
5. Multitap signature.
   - Stimulus: MULTITAP=1, STRB held high for 10 cycles.
   - Required: DI[1] = 0 while STRB is high; with MT_ID_LOW=0, DI[1] reflects pad 1 bit 0.
6. Reset mid-frame.
   - Stimulus: assert RESET_N=0 after 5 shifts.
   - Required: JOY_DI = 2'b11 immediately (asynchronous); after release with no strobe, clocks give DI[0] = 0 (fill); the next strobe restores normal frames.

Source files
------------

// File: rtl/snes_pad_responder.sv
// Controller-side SNES serial joypad responder: one standard pad or a 4-pad multitap.
// Console pins are double-registered into MCLK; edges are taken between the two stages.
module snes_pad_responder #(
    parameter int   NBITS     = 16,
    parameter logic MT_ID_LOW = 1'b1
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        MULTITAP,
    input  logic        JOY_STRB,
    input  logic        JOY_CLK,
    input  logic        JOY_P6,
    input  logic [11:0] BTN0,
    input  logic [11:0] BTN1,
    input  logic [11:0] BTN2,
    input  logic [11:0] BTN3,
    output logic [1:0]  JOY_DI,
    output logic        LATCH_PULSE
);

    localparam logic [4:0] CNT_MAX = 5'(NBITS);

    logic        strb_s1_r;
    logic        strb_s2_r;
    logic        clk_s1_r;
    logic        clk_s2_r;
    logic        p6_s1_r;
    logic        p6_s2_r;
    logic        mt_mode_r;
    logic [15:0] sr_r  [4];
    logic [4:0]  cnt_r [4];
    logic [11:0] btn_s [4];
    logic        clk_rise_s;
    logic        strb_fall_s;
    logic        id_force_s;
    logic [3:0]  shift_en_s;
    logic [3:0]  pad_bit_s;
    logic [1:0]  di_next_s;

    assign btn_s[0]    = BTN0;
    assign btn_s[1]    = BTN1;
    assign btn_s[2]    = BTN2;
    assign btn_s[3]    = BTN3;
    assign clk_rise_s  = clk_s1_r & ~clk_s2_r;
    assign strb_fall_s = ~strb_s1_r & strb_s2_r;
    assign id_force_s  = mt_mode_r & MT_ID_LOW & strb_s2_r;

    // Two-stage capture of the console-driven pins; reset values match their idle levels.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strb_s1_r <= 1'b0;
            strb_s2_r <= 1'b0;
            clk_s1_r  <= 1'b1;
            clk_s2_r  <= 1'b1;
            p6_s1_r   <= 1'b1;
            p6_s2_r   <= 1'b1;
        end else begin
            strb_s1_r <= JOY_STRB;
            strb_s2_r <= strb_s1_r;
            clk_s1_r  <= JOY_CLK;
            clk_s2_r  <= clk_s1_r;
            p6_s1_r   <= JOY_P6;
            p6_s2_r   <= p6_s1_r;
        end
    end

    // Pads addressed by a shift, and each pad's wire level (fill once the count saturates).
    always_comb begin
        shift_en_s = 4'b0000;
        pad_bit_s  = 4'b0000;
        if (!mt_mode_r) begin
            shift_en_s = 4'b0001;
        end else if (p6_s2_r) begin
            shift_en_s = 4'b0011;
        end else begin
            shift_en_s = 4'b1100;
        end
        for (int i = 0; i < 4; i++) begin
            if (cnt_r[i] < CNT_MAX) begin
                pad_bit_s[i] = ~sr_r[i][0];
            end else begin
                pad_bit_s[i] = 1'b0;
            end
        end
    end

    // Lane mux onto the two data lines; a strobed multitap can pull DI[1] low as its signature.
    always_comb begin
        di_next_s = 2'b11;
        case ({mt_mode_r, p6_s2_r})
            2'b11:   di_next_s = {pad_bit_s[1] & ~id_force_s, pad_bit_s[0]};
            2'b10:   di_next_s = {pad_bit_s[3] & ~id_force_s, pad_bit_s[2]};
            default: di_next_s = {1'b1, pad_bit_s[0]};
        endcase
    end

    // Per-pad frames: reload every cycle while strobed, otherwise shift the addressed pads.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                sr_r[i]  <= 16'hFFFF;
                cnt_r[i] <= CNT_MAX;
            end
            mt_mode_r <= 1'b0;
        end else if (strb_s2_r) begin
            for (int i = 0; i < 4; i++) begin
                sr_r[i]  <= {4'b0000, btn_s[i]};
                cnt_r[i] <= 5'd0;
            end
            mt_mode_r <= MULTITAP;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (clk_rise_s && shift_en_s[i]) begin
                    sr_r[i] <= {1'b1, sr_r[i][15:1]};
                    if (cnt_r[i] < CNT_MAX) begin
                        cnt_r[i] <= cnt_r[i] + 5'd1;
                    end
                end
            end
            mt_mode_r <= mt_mode_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            JOY_DI      <= 2'b11;
            LATCH_PULSE <= 1'b0;
        end else begin
            JOY_DI      <= di_next_s;
            LATCH_PULSE <= strb_fall_s;
        end
    end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Bench for snes_pad_responder: directed frames plus random pin traffic against a frame-position model.
module tb_snes_pad_responder;

    localparam int NB = 16;

    logic        mclk     = 1'b0;
    logic        rst_n    = 1'b0;
    logic        multitap = 1'b0;
    logic        joy_strb = 1'b0;
    logic        joy_clk  = 1'b1;
    logic        joy_p6   = 1'b1;
    logic [11:0] btn [4];
    logic [1:0]  di_a;
    logic [1:0]  di_b;
    logic        lp_a;
    logic        lp_b;

    int total = 0;
    int bad   = 0;
    int lp_cnt_a = 0;
    int lp_cnt_b = 0;
    int exp_lp   = 0;

    // Reference model: latched button snapshot and bit position of each pad.
    logic [11:0] frame [4];
    int          pos   [4];
    logic        m_mt   = 1'b0;
    logic        m_strb = 1'b0;
    logic        m_p6   = 1'b1;

    always #5 mclk = ~mclk;

    snes_pad_responder #(.NBITS(NB), .MT_ID_LOW(1'b1)) dut_a (
        .MCLK(mclk), .RESET_N(rst_n), .MULTITAP(multitap), .JOY_STRB(joy_strb),
        .JOY_CLK(joy_clk), .JOY_P6(joy_p6), .BTN0(btn[0]), .BTN1(btn[1]),
        .BTN2(btn[2]), .BTN3(btn[3]), .JOY_DI(di_a), .LATCH_PULSE(lp_a)
    );

    snes_pad_responder #(.NBITS(NB), .MT_ID_LOW(1'b0)) dut_b (
        .MCLK(mclk), .RESET_N(rst_n), .MULTITAP(multitap), .JOY_STRB(joy_strb),
        .JOY_CLK(joy_clk), .JOY_P6(joy_p6), .BTN0(btn[0]), .BTN1(btn[1]),
        .BTN2(btn[2]), .BTN3(btn[3]), .JOY_DI(di_b), .LATCH_PULSE(lp_b)
    );

    // Count latch pulses seen on each instance.
    always @(posedge mclk) begin
        if (lp_a) lp_cnt_a <= lp_cnt_a + 1;
        if (lp_b) lp_cnt_b <= lp_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wire level of one pad: buttons (0 = pressed), then ID bits read as 1, then fill low.
    function automatic logic pad_wire(input int i);
        if (pos[i] >= NB) return 1'b0;
        if (pos[i] < 12)  return ~frame[i][pos[i]];
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_di(input logic id_low);
        logic [1:0] e;
        if (!m_mt)     e = {1'b1, pad_wire(0)};
        else if (m_p6) e = {pad_wire(1), pad_wire(0)};
        else           e = {pad_wire(3), pad_wire(2)};
        if (id_low && m_mt && m_strb) e[1] = 1'b0;
        return e;
    endfunction

    function automatic logic addressed(input int i, input logic p6);
        if (!m_mt) return (i == 0);
        if (p6)    return (i < 2);
        return (i >= 2);
    endfunction

    // Drive one set of pin levels, advance the model, let the pipeline settle, then compare.
    task automatic step(input logic strb, input logic clk, input logic p6, input logic mt);
        logic rise;
        logic old_strb;
        logic old_p6;
        rise     = clk & ~joy_clk;
        old_strb = joy_strb;
        old_p6   = joy_p6;
        joy_strb = strb;
        joy_clk  = clk;
        joy_p6   = p6;
        multitap = mt;
        if (strb) begin
            for (int i = 0; i < 4; i++) begin
                frame[i] = btn[i];
                pos[i]   = 0;
            end
            m_mt = mt;
        end else if (rise && !old_strb) begin
            for (int i = 0; i < 4; i++) begin
                if (addressed(i, old_p6) && pos[i] < NB) pos[i]++;
            end
        end
        if (old_strb && !strb) exp_lp++;
        m_strb = strb;
        m_p6   = p6;
        repeat (5) @(negedge mclk);
        check("di_a", {30'd0, di_a}, {30'd0, exp_di(1'b1)});
        check("di_b", {30'd0, di_b}, {30'd0, exp_di(1'b0)});
        check("latch_cnt_a", lp_cnt_a, exp_lp);
        check("latch_cnt_b", lp_cnt_b, exp_lp);
    endtask

    task automatic strobe(input logic mt);
        step(1'b1, joy_clk, joy_p6, mt);
        step(1'b1, joy_clk, joy_p6, mt);
        step(1'b0, joy_clk, joy_p6, mt);
    endtask

    task automatic clk_pulse();
        step(1'b0, 1'b0, joy_p6, multitap);
        step(1'b0, 1'b1, joy_p6, multitap);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        joy_strb = 1'b0;
        joy_clk  = 1'b1;
        joy_p6   = 1'b1;
        #1;
        check("rst_di_a", {30'd0, di_a}, 32'h3);
        check("rst_di_b", {30'd0, di_b}, 32'h3);
        check("rst_latch", {31'd0, lp_a}, 32'h0);
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) pos[i] = NB;
        m_mt   = 1'b0;
        m_strb = 1'b0;
        m_p6   = 1'b1;
        repeat (5) @(negedge mclk);
        check("post_rst_fill", {30'd0, di_a}, 32'h2);
    endtask

    initial begin
        int lp_start;
        for (int i = 0; i < 4; i++) begin
            btn[i]   = 12'h000;
            frame[i] = 12'h000;
            pos[i]   = NB;
        end
        @(negedge mclk);
        do_reset();

        // Single pad, only B pressed.
        lp_start = exp_lp;
        btn[0] = 12'h001;
        strobe(1'b0);
        check("t1_first_bit", {30'd0, di_a}, 32'h2);
        clk_pulse();
        check("t1_bit1", {30'd0, di_a}, 32'h3);
        for (int k = 1; k < 16; k++) clk_pulse();
        check("t1_fill", {30'd0, di_a}, 32'h2);
        check("t1_one_latch", lp_cnt_a, lp_start + 1);

        // Saturation with every button held.
        btn[0] = 12'hFFF;
        strobe(1'b0);
        for (int k = 0; k < 20; k++) clk_pulse();
        check("t2_saturated", {30'd0, di_a}, 32'h2);

        // Multitap pair select.
        btn[0] = 12'h800; btn[1] = 12'h000; btn[2] = 12'h010; btn[3] = 12'h000;
        strobe(1'b1);
        for (int k = 0; k < 12; k++) clk_pulse();
        step(1'b0, joy_clk, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) clk_pulse();
        step(1'b0, joy_clk, 1'b1, 1'b1);

        // Clock edges while strobed are ignored.
        btn[0] = 12'h001;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_first_is_b", {30'd0, di_a}, 32'h2);

        // Multitap signature while strobed.
        btn[1] = 12'h000;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_sig_low", {31'd0, di_a[1]}, 32'h0);
        check("t5_no_sig", {31'd0, di_b[1]}, 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a frame, then fill, then a fresh frame.
        btn[0] = 12'h5A5;
        strobe(1'b0);
        for (int k = 0; k < 5; k++) clk_pulse();
        @(negedge mclk);
        do_reset();
        for (int k = 0; k < 3; k++) clk_pulse();
        check("t6_fill", {30'd0, di_a}, 32'h2);
        strobe(1'b0);
        for (int k = 0; k < 4; k++) clk_pulse();

        // Random pin traffic.
        for (int n = 0; n < 400; n++) begin
            logic s;
            logic c;
            logic p;
            logic m;
            if (joy_strb) s = ($urandom_range(0, 2) == 0);
            else          s = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 3) != 0) ? ~joy_clk : joy_clk;
            p = ($urandom_range(0, 5) == 0) ? ~joy_p6 : joy_p6;
            m = multitap;
            if (s || !joy_strb) begin
                if ($urandom_range(0, 5) == 0) m = ~multitap;
                if ($urandom_range(0, 3) == 0) begin
                    for (int i = 0; i < 4; i++) btn[i] = 12'($urandom);
                end
            end
            step(s, c, p, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
